// File: rtl/split_subtractor21.sv
// Multi-cycle carry-select subtractor: two passes over one segmented adder, then a ripple select.
// Define SPLIT_SUB_INREG_EN to capture a/b/bin on the start-accept edge.
module split_subtractor21 #(
  parameter int unsigned IO = 512,
  parameter int unsigned SS = (($clog2(IO) >> 2) > 0) ? (1 << ($clog2(IO) >> 2))
                                                       : (1 << ($clog2(IO) >> 1))
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [IO-1:0] a,
  input  logic [IO-1:0] b,
  input  logic          bin,
  output logic          busy,
  output logic [IO-1:0] diff,
  output logic          borrow,
  output logic          done
);

  localparam int unsigned N_PARTS = (IO + SS - 1) / SS;
  localparam int unsigned LAST_W  = IO - SS * (N_PARTS - 1);

  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] SUB0 = 4'b0010;
  localparam logic [3:0] SUB1 = 4'b0100;
  localparam logic [3:0] SEL  = 4'b1000;

  logic [3:0]         state_q, state_d;
  logic [IO-1:0]      psum0_q, psum0_d, psum1_q, psum1_d;
  logic [N_PARTS-1:0] cout0_q, cout0_d, cout1_q, cout1_d;
  logic [IO-1:0]      diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               done_q, done_d;

  logic [IO-1:0]      op_a_c, op_b_c;
  logic               op_bin_c;
  logic               pass_cin_c;
  logic [IO-1:0]      seg_sum_c;
  logic [N_PARTS-1:0] seg_cout_c;
  logic [N_PARTS:0]   sel_carry_c;
  logic [IO-1:0]      sel_diff_c;

`ifdef SPLIT_SUB_INREG_EN
  logic [IO-1:0] a_q, a_d, b_q, b_d;
  logic          bin_q, bin_d;

  // Operand copies captured only when a new request is accepted
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    bin_d = bin_q;
    if ((state_q == IDLE) && start) begin
      a_d   = a;
      b_d   = b;
      bin_d = bin;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      bin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      bin_q <= bin_d;
    end
  end

  assign op_a_c   = a_q;
  assign op_b_c   = b_q;
  assign op_bin_c = bin_q;
`else
  assign op_a_c   = a;
  assign op_b_c   = b;
  assign op_bin_c = bin;
`endif

  assign pass_cin_c     = (state_q == SUB1);
  assign sel_carry_c[0] = ~op_bin_c;

  // Per-segment a + ~b + pass carry, plus the select ripple over the stored pass results
  for (genvar g = 0; g < N_PARTS; g++) begin : g_seg
    localparam int unsigned LO = g * SS;
    localparam int unsigned W  = (g == N_PARTS - 1) ? LAST_W : SS;
    logic [W:0] seg_c;

    assign seg_c = {1'b0, op_a_c[LO +: W]} + {1'b0, ~op_b_c[LO +: W]} + (W+1)'(pass_cin_c);
    assign seg_sum_c[LO +: W] = seg_c[W-1:0];
    assign seg_cout_c[g]      = seg_c[W];

    assign sel_diff_c[LO +: W] = sel_carry_c[g] ? psum1_q[LO +: W] : psum0_q[LO +: W];
    assign sel_carry_c[g+1]    = sel_carry_c[g] ? cout1_q[g] : cout0_q[g];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    psum0_d  = psum0_q;
    psum1_d  = psum1_q;
    cout0_d  = cout0_q;
    cout1_d  = cout1_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = SUB0;
      SUB0: begin
        psum0_d = seg_sum_c;
        cout0_d = seg_cout_c;
        state_d = SUB1;
      end
      SUB1: begin
        psum1_d = seg_sum_c;
        cout1_d = seg_cout_c;
        state_d = SEL;
      end
      SEL: begin
        diff_d   = sel_diff_c;
        borrow_d = ~sel_carry_c[N_PARTS];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      psum0_q  <= '0;
      psum1_q  <= '0;
      cout0_q  <= '0;
      cout1_q  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      psum0_q  <= psum0_d;
      psum1_q  <= psum1_d;
      cout0_q  <= cout0_d;
      cout1_q  <= cout1_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign done   = done_q;

endmodule
